mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/singlecycle_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/singlecycle_pkg.sv
// Shared types and constants for the data-memory arbiter.
package singlecycle_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Arbitration modes
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Master identifier: 0 = LSU (M0), 1 = fetch (M1)
  typedef logic arb_id_t;

  localparam arb_id_t ID_M0 = 1'b0;
  localparam arb_id_t ID_M1 = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision between the two masters.
// STARVE_LIM must be at least 1.
module mem_arb_pick
  import singlecycle_pkg::*;
#(
  parameter int ARB_MODE   = ARB_FIXED,
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = $clog2(STARVE_LIM + 1)
) (
  input  logic             m0_valid,
  input  logic             m1_valid,
  input  logic [CNT_W-1:0] wait_cnt,
  input  arb_id_t          last_grant,
  output arb_id_t          grant_id,
  output logic             grant_valid
);

  // Pick a winner; M1 only loses a tie unless starved (fixed) or it is its turn (RR)
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = m0_valid | m1_valid;
    grant_id    = ID_M0;
    if (m0_valid && m1_valid) begin
      if (ARB_MODE == ARB_RR) begin
        grant_id = (last_grant == ID_M0) ? ID_M1 : ID_M0;
      end else if (wait_cnt == CNT_W'(STARVE_LIM)) begin
        grant_id = ID_M1;
      end
    end else if (m1_valid) begin
      grant_id = ID_M1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of data_mem: grants one request at a time,
// holds it toward data_mem until completion, then pulses the winner's READY.
module mem_arbiter
  import singlecycle_pkg::*;
#(
  parameter int ARB_MODE   = ARB_FIXED,
  parameter int STARVE_LIM = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // master 0 (LSU)
  input  logic [17:0] i_M0_ADDR,
  input  logic [31:0] i_M0_WDATA,
  input  logic [3:0]  i_M0_BMASK,
  input  logic        i_M0_WREN,
  input  logic        i_M0_VALID,
  output logic        o_M0_READY,
  output logic [31:0] o_M0_RDATA,
  // master 1 (fetch)
  input  logic [17:0] i_M1_ADDR,
  input  logic [31:0] i_M1_WDATA,
  input  logic [3:0]  i_M1_BMASK,
  input  logic        i_M1_WREN,
  input  logic        i_M1_VALID,
  output logic        o_M1_READY,
  output logic [31:0] o_M1_RDATA,
  // data_mem side
  output logic [17:0] o_ADDR,
  output logic [31:0] o_WDATA,
  output logic [3:0]  o_BMASK,
  output logic        o_WREN,
  output logic        o_VALID,
  input  logic        i_READY,
  input  logic [31:0] i_RDATA
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  arb_state_e       state;
  logic [17:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       bmask_q;
  logic             wren_q;
  arb_id_t          id_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] wait_cnt;
  arb_id_t          last_grant;

  arb_id_t          grant_id;
  logic             grant_valid;

  mem_arb_pick #(
    .ARB_MODE   (ARB_MODE),
    .STARVE_LIM (STARVE_LIM),
    .CNT_W      (CNT_W)
  ) u_pick (
    .m0_valid    (i_M0_VALID),
    .m1_valid    (i_M1_VALID),
    .wait_cnt    (wait_cnt),
    .last_grant  (last_grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  // Request fields toward data_mem always come from the captured copy
  assign o_ADDR     = addr_q;
  assign o_WDATA    = wdata_q;
  assign o_BMASK    = bmask_q;
  assign o_WREN     = wren_q;
  assign o_M0_RDATA = rdata_q;
  assign o_M1_RDATA = rdata_q;

  // Arbiter FSM: grant and capture in IDLE, present in BUSY, answer in RESP
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (i_rst) begin
      state      <= IDLE;
      o_VALID    <= 1'b0;
      o_M0_READY <= 1'b0;
      o_M1_READY <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bmask_q    <= '0;
      wren_q     <= 1'b0;
      id_q       <= ID_M0;
      rdata_q    <= '0;
      wait_cnt   <= '0;
      last_grant <= ID_M1;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            state      <= BUSY;
            o_VALID    <= 1'b1;
            id_q       <= grant_id;
            last_grant <= grant_id;
            if (grant_id == ID_M0) begin
              addr_q  <= i_M0_ADDR;
              wdata_q <= i_M0_WDATA;
              bmask_q <= i_M0_BMASK;
              wren_q  <= i_M0_WREN;
            end else begin
              addr_q  <= i_M1_ADDR;
              wdata_q <= i_M1_WDATA;
              bmask_q <= i_M1_BMASK;
              wren_q  <= i_M1_WREN;
            end
            // M1 starvation tracking: count M0 wins it lost, clear when M1 wins
            if (grant_id == ID_M1) begin
              wait_cnt <= '0;
            end else if (i_M1_VALID && (wait_cnt != CNT_W'(STARVE_LIM))) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        BUSY: begin
          if (i_READY) begin
            state      <= RESP;
            o_VALID    <= 1'b0;
            rdata_q    <= i_RDATA;
            o_M0_READY <= (id_q == ID_M0);
            o_M1_READY <= (id_q == ID_M1);
          end
        end
        RESP: begin
          // o_VALID is already low here, giving data_mem a clean gap before the next request
          state      <= IDLE;
          o_M0_READY <= 1'b0;
          o_M1_READY <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          o_VALID    <= 1'b0;
          o_M0_READY <= 1'b0;
          o_M1_READY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: one fixed-priority and one round-robin
// instance, each fronting a small behavioural data_mem responder.
module tb_mem_arbiter;
  import singlecycle_pkg::*;

  localparam int LIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- fixed-priority instance ----------------
  logic        f_rst = 1'b1;
  logic [17:0] f_m0_addr = '0, f_m1_addr = '0;
  logic [31:0] f_m0_wdata = '0, f_m1_wdata = '0;
  logic [3:0]  f_m0_bmask = '0, f_m1_bmask = '0;
  logic        f_m0_wren = 1'b0, f_m1_wren = 1'b0;
  logic        f_m0_valid = 1'b0, f_m1_valid = 1'b0;
  logic        f_m0_ready, f_m1_ready;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic [17:0] f_addr;
  logic [31:0] f_wdata;
  logic [3:0]  f_bmask;
  logic        f_wren, f_valid;
  logic        f_mem_ready = 1'b0;
  logic        f_spur = 1'b0;
  logic [31:0] f_mem_rdata = '0;

  mem_arbiter #(.ARB_MODE(ARB_FIXED), .STARVE_LIM(LIM)) u_fix (
    .i_clk      (clk),
    .i_rst      (f_rst),
    .i_M0_ADDR  (f_m0_addr),
    .i_M0_WDATA (f_m0_wdata),
    .i_M0_BMASK (f_m0_bmask),
    .i_M0_WREN  (f_m0_wren),
    .i_M0_VALID (f_m0_valid),
    .o_M0_READY (f_m0_ready),
    .o_M0_RDATA (f_m0_rdata),
    .i_M1_ADDR  (f_m1_addr),
    .i_M1_WDATA (f_m1_wdata),
    .i_M1_BMASK (f_m1_bmask),
    .i_M1_WREN  (f_m1_wren),
    .i_M1_VALID (f_m1_valid),
    .o_M1_READY (f_m1_ready),
    .o_M1_RDATA (f_m1_rdata),
    .o_ADDR     (f_addr),
    .o_WDATA    (f_wdata),
    .o_BMASK    (f_bmask),
    .o_WREN     (f_wren),
    .o_VALID    (f_valid),
    .i_READY    (f_mem_ready | f_spur),
    .i_RDATA    (f_mem_rdata)
  );

  // ---------------- round-robin instance ----------------
  logic        r_rst = 1'b1;
  logic        r_m0_valid = 1'b0, r_m1_valid = 1'b0;
  logic        r_m0_ready, r_m1_ready;
  logic [31:0] r_m0_rdata, r_m1_rdata;
  logic [17:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_bmask;
  logic        r_wren, r_valid;
  logic        r_mem_ready = 1'b0;

  mem_arbiter #(.ARB_MODE(ARB_RR), .STARVE_LIM(LIM)) u_rr (
    .i_clk      (clk),
    .i_rst      (r_rst),
    .i_M0_ADDR  (18'h00100),
    .i_M0_WDATA (32'h0),
    .i_M0_BMASK (4'h0),
    .i_M0_WREN  (1'b0),
    .i_M0_VALID (r_m0_valid),
    .o_M0_READY (r_m0_ready),
    .o_M0_RDATA (r_m0_rdata),
    .i_M1_ADDR  (18'h00200),
    .i_M1_WDATA (32'h0),
    .i_M1_BMASK (4'h0),
    .i_M1_WREN  (1'b0),
    .i_M1_VALID (r_m1_valid),
    .o_M1_READY (r_m1_ready),
    .o_M1_RDATA (r_m1_rdata),
    .o_ADDR     (r_addr),
    .o_WDATA    (r_wdata),
    .o_BMASK    (r_bmask),
    .o_WREN     (r_wren),
    .o_VALID    (r_valid),
    .i_READY    (r_mem_ready),
    .i_RDATA    (32'h0)
  );

  // ---------------- behavioural data_mem for the fixed instance ----------------
  logic [31:0] mem [int];
  int          f_lat = 1;
  int          f_cnt = 0;
  int          f_word;

  function automatic logic [31:0] mem_merge(logic [31:0] old, logic [31:0] wd, logic [3:0] bm);
    for (int b = 0; b < 4; b++) if (bm[b]) old[8*b +: 8] = wd[8*b +: 8];
    return old;
  endfunction

  // Answers f_lat negedges after the request appears, one-cycle READY pulse
  always @(negedge clk) begin
    if (f_rst) begin
      f_cnt       = 0;
      f_mem_ready = 1'b0;
    end else if (f_mem_ready) begin
      f_mem_ready = 1'b0;
    end else if (f_valid) begin
      f_cnt++;
      if (f_cnt >= f_lat) begin
        f_cnt  = 0;
        f_word = int'(f_addr[17:2]);
        if (f_wren) mem[f_word] = mem_merge(mem.exists(f_word) ? mem[f_word] : 32'h0, f_wdata, f_bmask);
        f_mem_rdata = mem.exists(f_word) ? mem[f_word] : 32'h0;
        f_mem_ready = 1'b1;
      end
    end
  end

  // Fixed two-cycle responder for the round-robin instance
  int r_cnt = 0;
  always @(negedge clk) begin
    if (r_rst) begin
      r_cnt       = 0;
      r_mem_ready = 1'b0;
    end else if (r_mem_ready) begin
      r_mem_ready = 1'b0;
    end else if (r_valid) begin
      r_cnt++;
      if (r_cnt >= 2) begin
        r_cnt       = 0;
        r_mem_ready = 1'b1;
      end
    end
  end

  // ---------------- reference memory (word-level byte-lane model) ----------------
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_read(logic [17:0] a);
    int k = int'(a >> 2);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  function automatic void ref_write(logic [17:0] a, logic [31:0] wd, logic [3:0] bm);
    logic [31:0] lanes = {{8{bm[3]}}, {8{bm[2]}}, {8{bm[1]}}, {8{bm[0]}}};
    ref_mem[int'(a >> 2)] = (ref_read(a) & ~lanes) | (wd & lanes);
  endfunction

  // One cycle point = 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-master transaction from IDLE, checked against the reference model
  task automatic do_txn(input bit m, input logic [17:0] a, input logic [31:0] wd,
                        input logic [3:0] bm, input bit we, output logic [31:0] rd);
    logic [31:0] exp_rd;
    bit          got;
    bit          prev_rdy;
    exp_rd = ref_read(a);
    if (!m) begin
      f_m0_addr = a; f_m0_wdata = wd; f_m0_bmask = bm; f_m0_wren = we; f_m0_valid = 1'b1;
    end else begin
      f_m1_addr = a; f_m1_wdata = wd; f_m1_bmask = bm; f_m1_wren = we; f_m1_valid = 1'b1;
    end
    step();
    n_cmp++;
    if (f_valid !== 1'b1) begin
      n_err++; $display("FAIL txn_latency: o_VALID=%b expected 1 one cycle after request", f_valid);
    end
    n_cmp++;
    if ({f_addr, f_wdata, f_bmask, f_wren} !== {a, wd, bm, we}) begin
      n_err++;
      $display("FAIL txn_fields: got addr=%h wdata=%h bmask=%h wren=%b expected %h %h %h %b",
               f_addr, f_wdata, f_bmask, f_wren, a, wd, bm, we);
    end
    got = 1'b0;
    rd  = '0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      prev_rdy = f_mem_ready | f_spur;
      #1;
      n_cmp++;
      if ((m ? f_m0_ready : f_m1_ready) !== 1'b0) begin
        n_err++; $display("FAIL txn_wrong_master: READY on M%0d, expected only M%0d", !m, m);
      end
      if ((m ? f_m1_ready : f_m0_ready) === 1'b1) begin
        got = 1'b1;
        rd  = m ? f_m1_rdata : f_m0_rdata;
        f_m0_valid = 1'b0;
        f_m1_valid = 1'b0;
        n_cmp++;
        if (prev_rdy !== 1'b1) begin
          n_err++; $display("FAIL txn_ready_timing: READY=1 but i_READY at previous edge=%b expected 1", prev_rdy);
        end
        if (!we) begin
          n_cmp++;
          if (rd !== exp_rd) begin
            n_err++; $display("FAIL txn_rdata: addr=%h got %h expected %h", a, rd, exp_rd);
          end
        end
      end
    end
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL txn_timeout: no READY for M%0d within 60 cycles (actual none, expected pulse)", m);
      f_m0_valid = 1'b0;
      f_m1_valid = 1'b0;
    end
    if (we) ref_write(a, wd, bm);
    step();
    n_cmp++;
    if ({f_m0_ready, f_m1_ready, f_valid} !== 3'b000) begin
      n_err++; $display("FAIL txn_ready_pulse_width: READY0/READY1/VALID=%b expected 000",
                        {f_m0_ready, f_m1_ready, f_valid});
    end
  endtask

  task automatic test_reset();
    f_rst = 1'b1; r_rst = 1'b1;
    step(); step();
    f_rst = 1'b0; r_rst = 1'b0;
    n_cmp++;
    if ({f_valid, f_m0_ready, f_m1_ready, f_addr, f_wdata, f_bmask, f_wren, f_m0_rdata, f_m1_rdata} !== '0) begin
      n_err++; $display("FAIL reset_fixed: valid=%b rdy=%b%b addr=%h rdata=%h expected all zero",
                        f_valid, f_m0_ready, f_m1_ready, f_addr, f_m0_rdata);
    end
    n_cmp++;
    if ({r_valid, r_m0_ready, r_m1_ready, r_m0_rdata} !== '0) begin
      n_err++; $display("FAIL reset_rr: valid=%b rdy=%b%b rdata=%h expected all zero",
                        r_valid, r_m0_ready, r_m1_ready, r_m0_rdata);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    f_lat = 9;
    do_txn(1'b0, 18'h00010, 32'hDEADBEEF, 4'hF, 1'b1, rd);
    do_txn(1'b1, 18'h00010, 32'h0, 4'h0, 1'b0, rd);
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL write_read: M1 read %h expected DEADBEEF", rd);
    end
    f_lat = 2;
  endtask

  task automatic test_byte_write();
    logic [31:0] rd;
    do_txn(1'b0, 18'h00040, 32'h11223344, 4'hF, 1'b1, rd);
    do_txn(1'b0, 18'h00040, 32'h0000AB00, 4'h2, 1'b1, rd);
    do_txn(1'b1, 18'h00040, 32'h0, 4'h0, 1'b0, rd);
    n_cmp++;
    if (rd !== 32'h1122AB44) begin
      n_err++; $display("FAIL byte_write: read %h expected 1122AB44", rd);
    end
  endtask

  task automatic test_spurious_ready();
    logic [31:0] rd;
    logic [31:0] held = f_m0_rdata;
    f_spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({f_valid, f_m0_ready, f_m1_ready} !== 3'b000 || f_m0_rdata !== held) begin
        n_err++; $display("FAIL spurious_ready: valid/rdy=%b rdata=%h expected 000 and %h",
                          {f_valid, f_m0_ready, f_m1_ready}, f_m0_rdata, held);
      end
    end
    f_spur = 1'b0;
    do_txn(1'b0, 18'h00044, 32'hCAFEF00D, 4'hF, 1'b1, rd);
  endtask

  task automatic test_capture_once();
    logic [31:0] rd;
    bit          got = 1'b0;
    f_lat = 4;
    f_m0_addr = 18'h00080; f_m0_wdata = 32'h55AA55AA; f_m0_bmask = 4'hF; f_m0_wren = 1'b1;
    f_m0_valid = 1'b1;
    step();
    // protocol violation plus early drop of VALID
    f_m0_addr = 18'h3FFFC; f_m0_wdata = 32'h0; f_m0_bmask = 4'h1; f_m0_valid = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (f_valid === 1'b1) begin
        n_cmp++;
        if ({f_addr, f_wdata, f_bmask} !== {18'h00080, 32'h55AA55AA, 4'hF}) begin
          n_err++; $display("FAIL capture_once: addr=%h wdata=%h bmask=%h expected 00080 55aa55aa f",
                            f_addr, f_wdata, f_bmask);
        end
      end
      step();
      if (f_m0_ready === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL dropped_valid_ready: M0 READY=0 expected a pulse");
    end
    step();
    ref_write(18'h00080, 32'h55AA55AA, 4'hF);
    f_lat = 2;
    do_txn(1'b1, 18'h00080, 32'h0, 4'h0, 1'b0, rd);
  endtask

  task automatic test_reset_busy();
    logic [31:0] rd;
    bit          bad = 1'b0;
    f_lat = 9;
    f_m0_addr = 18'h00010; f_m0_wdata = 32'h01234567; f_m0_bmask = 4'hF; f_m0_wren = 1'b1;
    f_m0_valid = 1'b1;
    step();
    step();
    f_rst = 1'b1; f_m0_valid = 1'b0;
    step();
    f_rst = 1'b0;
    n_cmp++;
    if ({f_valid, f_m0_ready, f_m1_ready} !== 3'b000) begin
      n_err++; $display("FAIL reset_busy: valid/rdy=%b expected 000", {f_valid, f_m0_ready, f_m1_ready});
    end
    for (int i = 0; i < 12; i++) begin
      step();
      if ({f_valid, f_m0_ready, f_m1_ready} !== 3'b000) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++; $display("FAIL reset_busy_quiet: activity after abandoned transaction, expected none");
    end
    f_lat = 3;
    do_txn(1'b1, 18'h00010, 32'h0, 4'h0, 1'b0, rd);
  endtask

  task automatic test_fixed_priority();
    bit exp_id;
    bit got_id;
    bit last_v = 1'b0;
    int model_cnt = 0;
    int ngrant = 0;
    f_rst = 1'b1; step(); f_rst = 1'b0;
    f_m0_addr = 18'h00100; f_m0_wren = 1'b0; f_m0_valid = 1'b1;
    f_m1_addr = 18'h00200; f_m1_wren = 1'b0; f_m1_valid = 1'b1;
    for (int i = 0; i < 300 && ngrant < 10; i++) begin
      f_lat = int'($urandom_range(1, 3));
      step();
      if (f_valid === 1'b1 && !last_v) begin
        // starvation model: M1 wins only after LIM straight losses
        if (model_cnt == LIM) begin exp_id = 1'b1; model_cnt = 0; end
        else begin exp_id = 1'b0; model_cnt = model_cnt + 1; end
        got_id = (f_addr == 18'h00200);
        n_cmp++;
        if (got_id !== exp_id) begin
          n_err++; $display("FAIL fixed_order[%0d]: granted M%0d expected M%0d", ngrant, got_id, exp_id);
        end
        ngrant++;
      end
      last_v = f_valid;
    end
    n_cmp++;
    if (ngrant != 10) begin
      n_err++; $display("FAIL fixed_order_count: saw %0d grants expected 10", ngrant);
    end
    f_m0_valid = 1'b0; f_m1_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    f_lat = 2;
  endtask

  task automatic test_round_robin();
    bit exp_id = 1'b1;
    bit got_id;
    bit last_v = 1'b0;
    int ngrant = 0;
    r_rst = 1'b1; r_m0_valid = 1'b1; r_m1_valid = 1'b1;
    step();
    r_rst = 1'b0;
    for (int i = 0; i < 100 && ngrant < 6; i++) begin
      step();
      if (r_valid === 1'b1 && !last_v) begin
        exp_id = !exp_id;
        got_id = (r_addr == 18'h00200);
        n_cmp++;
        if (got_id !== exp_id) begin
          n_err++; $display("FAIL rr_order[%0d]: granted M%0d expected M%0d", ngrant, got_id, exp_id);
        end
        ngrant++;
      end
      last_v = r_valid;
    end
    n_cmp++;
    if (ngrant != 6) begin
      n_err++; $display("FAIL rr_order_count: saw %0d grants expected 6", ngrant);
    end
    r_m0_valid = 1'b0; r_m1_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [17:0] a;
    for (int i = 0; i < 30; i++) begin
      f_lat = int'($urandom_range(1, 6));
      a = {12'h0, 4'($urandom_range(0, 7)), 2'($urandom)};
      do_txn(1'($urandom), a, $urandom, 4'($urandom), 1'($urandom), rd);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    test_reset();
    test_write_read();
    test_byte_write();
    test_spurious_ready();
    test_capture_once();
    test_reset_busy();
    test_fixed_priority();
    test_round_robin();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
